// File: rtl/m_uart_arb_if.sv
// Requester-side and UART-transmitter-side signals of the m_uart_arb byte arbiter.
// master = requesters plus UART model, slave = the arbiter.
interface m_uart_arb_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   w_req_valid;
   logic [8*NREQ-1:0] w_req_data;
   logic [NREQ-1:0]   w_req_last;
   logic [NREQ-1:0]   r_req_ack;
   logic              r_uart_we;
   logic [7:0]        r_uart_data;
   logic              w_uart_ready;
   logic [1:0]        r_grant;
   logic              r_locked;
   logic              r_busy;

   modport master (
      output w_req_valid, w_req_data, w_req_last, w_uart_ready,
      input  r_req_ack, r_uart_we, r_uart_data, r_grant, r_locked, r_busy
   );

   modport slave (
      input  w_req_valid, w_req_data, w_req_last, w_uart_ready,
      output r_req_ack, r_uart_we, r_uart_data, r_grant, r_locked, r_busy
   );
endinterface

// File: rtl/m_uart_arb.sv
// Round-robin, message-locking arbiter feeding bytes from four requesters into one UART transmitter.
// Optional lock watchdog compiled in by defining UART_ARB_TIMEOUT_EN.
module m_uart_arb #(
   parameter int NREQ        = 4,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic         w_clk,
   input  logic         w_rst_n,
   m_uart_arb_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

   state_t     state_reg, state_next;
   logic [7:0] uart_data_reg;
   logic [1:0] grant_reg;
   logic       locked_reg;
   logic [7:0] req_byte [NREQ];
   logic       decide;
   logic       sel_found;
   logic [1:0] sel_idx;
   logic [1:0] cand;
   logic       wdog_hit;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_byte[gi]      = bus.w_req_data[8*gi +: 8];
      assign bus.r_req_ack[gi] = (state_reg == ISSUE) && (grant_reg == 2'(gi));
   end

   // Descending scan so the nearest requester after the last grant wins; the
   // last grantee itself (k = NREQ) has the lowest priority.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = grant_reg;
      cand      = grant_reg;
      if (locked_reg) begin
         sel_found = bus.w_req_valid[grant_reg];
      end else begin
         for (int k = NREQ; k >= 1; k--) begin
            cand = grant_reg + 2'(k);
            if (bus.w_req_valid[cand]) begin
               sel_found = 1'b1;
               sel_idx   = cand;
            end
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      decide     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.w_uart_ready && sel_found) begin
               decide     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE:     state_next = WAIT_LOW;
         WAIT_LOW:  if (!bus.w_uart_ready) state_next = WAIT_HIGH;
         WAIT_HIGH: if (bus.w_uart_ready) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_reg     <= IDLE;
         uart_data_reg <= 8'h00;
         grant_reg     <= 2'd3;
         locked_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (decide) begin
            uart_data_reg <= req_byte[sel_idx];
            grant_reg     <= sel_idx;
            locked_reg    <= ~bus.w_req_last[sel_idx];
         end else if (wdog_hit) begin
            locked_reg <= 1'b0;
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TW-1:0] wdog_reg;
   logic          holder_gone;

   // Only idle time spent waiting on an absent lock holder counts toward release.
   assign holder_gone = (state_reg == IDLE) && locked_reg && !bus.w_req_valid[grant_reg];
   assign wdog_hit    = holder_gone && (wdog_reg == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         wdog_reg <= '0;
      end else if ((state_reg == ISSUE) || !locked_reg || wdog_hit) begin
         wdog_reg <= '0;
      end else if (holder_gone) begin
         wdog_reg <= wdog_reg + 1'b1;
      end
   end
`else
   assign wdog_hit = 1'b0;
`endif

   assign bus.r_uart_we   = (state_reg == ISSUE);
   assign bus.r_uart_data = uart_data_reg;
   assign bus.r_grant     = grant_reg;
   assign bus.r_locked    = locked_reg;
   assign bus.r_busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_m_uart_arb.sv
// Directed self-checking bench for m_uart_arb: per-requester byte queues, a simple UART
// model with a fixed byte time, and a strobe log checked against hand-computed values.
module tb_m_uart_arb;
   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } req_byte_t;

   typedef struct packed {
      logic [31:0] cyc;
      logic [1:0]  grant;
      logic [7:0]  data;
      logic [3:0]  ack;
      logic        locked;
   } strobe_t;

   logic        w_clk   = 1'b0;
   logic        w_rst_n = 1'b0;
   logic        hold_low = 1'b0;
   int          tx_left  = 0;
   logic [31:0] cyc      = 0;
   int          total    = 0;
   int          bad      = 0;
   int          ack_total = 0;

   req_byte_t req_q [4][$];
   strobe_t   log_q [$];

   m_uart_arb_if #(.NREQ(4)) arb_bus ();

   m_uart_arb #(
      .NREQ        (4),
      .TIMEOUT_CYC (16)
   ) dut (
      .w_clk   (w_clk),
      .w_rst_n (w_rst_n),
      .bus     (arb_bus)
   );

   always #10 w_clk = ~w_clk;

   // UART model: busy for four cycles starting the cycle after a sampled strobe.
   assign arb_bus.w_uart_ready = (tx_left == 0) && !hold_low;

   initial forever begin
      @(posedge w_clk);
      cyc = cyc + 1;
   end

   initial forever begin
      @(posedge w_clk);
      if (arb_bus.r_uart_we === 1'b1) tx_left <= 4;
      else if (tx_left != 0)          tx_left <= tx_left - 1;
   end

   // Requesters: present the queue head, pop it when acknowledged.
   initial begin : drv
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      arb_bus.w_req_valid = '0;
      arb_bus.w_req_data  = '0;
      arb_bus.w_req_last  = '0;
      forever begin
         @(negedge w_clk);
         for (int i = 0; i < 4; i++)
            if (arb_bus.r_req_ack[i] === 1'b1 && req_q[i].size() != 0) void'(req_q[i].pop_front());
         v = '0; l = '0; d = '0;
         for (int i = 0; i < 4; i++) begin
            if (req_q[i].size() != 0) begin
               v[i]        = 1'b1;
               d[8*i +: 8] = req_q[i][0].d;
               l[i]        = req_q[i][0].l;
            end
         end
         arb_bus.w_req_valid = v;
         arb_bus.w_req_data  = d;
         arb_bus.w_req_last  = l;
      end
   end

   initial forever begin
      @(negedge w_clk);
      if (arb_bus.r_uart_we === 1'b1) begin
         log_q.push_back({cyc, arb_bus.r_grant, arb_bus.r_uart_data, arb_bus.r_req_ack, arb_bus.r_locked});
         $display("strobe cyc=%0d grant=%0d data=%02h ack=%b locked=%b", cyc, arb_bus.r_grant,
                  arb_bus.r_uart_data, arb_bus.r_req_ack, arb_bus.r_locked);
      end
      ack_total += $countones(arb_bus.r_req_ack);
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish, expected finish before time limit");
      $fatal(1, "bench time limit");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int i, input logic [7:0] d, input logic l);
      req_q[i].push_back('{d: d, l: l});
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge w_clk);
         #1;
      end
   endtask

   task automatic wait_strobes(input int target, input int budget, input string tag);
      int n = 0;
      while (log_q.size() < target && n < budget) begin
         step(1);
         n++;
      end
      check_val({tag, "_count"}, log_q.size(), target);
   endtask

   task automatic reset_dut();
      w_rst_n = 1'b0;
      step(2);
      w_rst_n = 1'b1;
      step(1);
   endtask

   function automatic strobe_t strobe_at(input int idx);
      strobe_t s = '1;
      if (idx < log_q.size()) s = log_q[idx];
      return s;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_we"},     arb_bus.r_uart_we,   1'b0);
      check_val({tag, "_data"},   arb_bus.r_uart_data, 8'h00);
      check_val({tag, "_ack"},    arb_bus.r_req_ack,   4'b0000);
      check_val({tag, "_grant"},  arb_bus.r_grant,     2'd3);
      check_val({tag, "_locked"}, arb_bus.r_locked,    1'b0);
      check_val({tag, "_busy"},   arb_bus.r_busy,      1'b0);
   endtask

   initial begin : main
      int          base;
      int          ack0;
      int          n;
      logic [31:0] c0;
      strobe_t     s;
      strobe_t     s0;
      logic [1:0]  rr_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [7:0]  rr_d [5] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h05};
      logic [1:0]  lk_g [4] = '{2'd2, 2'd2, 2'd2, 2'd1};
      logic [7:0]  lk_d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
      logic        lk_l [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

      // Reset state
      step(3);
      check_reset_outputs("rst");
      w_rst_n = 1'b1;
      step(1);

      // Single byte, one-cycle strobe latency
      base = log_q.size();
      c0   = cyc;
      push(0, 8'h61, 1'b1);
      wait_strobes(base + 1, 50, "single");
      s = strobe_at(base);
      check_val("single_data",    s.data,     8'h61);
      check_val("single_ack",     s.ack,      4'b0001);
      check_val("single_grant",   s.grant,    2'd0);
      check_val("single_locked",  s.locked,   1'b0);
      check_val("single_latency", s.cyc - c0, 32'd1);

      // Round-robin from reset: all last=1
      reset_dut();
      base = log_q.size();
      push(0, 8'h01, 1'b1);
      push(0, 8'h05, 1'b1);
      push(1, 8'h11, 1'b1);
      push(2, 8'h21, 1'b1);
      push(3, 8'h31, 1'b1);
      wait_strobes(base + 5, 300, "rr");
      for (int i = 0; i < 5; i++) begin
         s = strobe_at(base + i);
         check_val($sformatf("rr_grant%0d", i), s.grant, rr_g[i]);
         check_val($sformatf("rr_data%0d", i),  s.data,  rr_d[i]);
         check_val($sformatf("rr_ack%0d", i),   s.ack,   4'b0001 << rr_g[i]);
      end

      // Message lock: req1 goes first so req2 is next in round-robin order
      step(10);
      base = log_q.size();
      push(1, 8'h1A, 1'b1);
      wait_strobes(base + 1, 50, "lk_pre");
      check_val("lk_pre_grant", strobe_at(base).grant, 2'd1);
      push(2, 8'hA0, 1'b0);
      push(2, 8'hA1, 1'b0);
      push(2, 8'hA2, 1'b1);
      push(1, 8'hB0, 1'b1);
      wait_strobes(base + 5, 300, "lk");
      for (int i = 0; i < 4; i++) begin
         s = strobe_at(base + 1 + i);
         check_val($sformatf("lk_grant%0d", i),  s.grant,  lk_g[i]);
         check_val($sformatf("lk_data%0d", i),   s.data,   lk_d[i]);
         check_val($sformatf("lk_locked%0d", i), s.locked, lk_l[i]);
      end

      // Backpressure: ready low for 500 cycles
      step(10);
      hold_low = 1'b1;
      base = log_q.size();
      ack0 = ack_total;
      push(0, 8'h5C, 1'b1);
      step(500);
      check_val("bp_no_strobe", log_q.size(), base);
      check_val("bp_no_ack",    ack_total,    ack0);
      check_val("bp_busy",      arb_bus.r_busy, 1'b0);
      hold_low = 1'b0;
      wait_strobes(base + 1, 50, "bp");
      step(30);
      check_val("bp_one_strobe", log_q.size(), base + 1);
      s = strobe_at(base);
      check_val("bp_data",  s.data,  8'h5C);
      check_val("bp_grant", s.grant, 2'd0);

      // Reset in WAIT_HIGH while locked, with a UART byte still in flight
      step(10);
      base = log_q.size();
      push(2, 8'hC0, 1'b0);
      wait_strobes(base + 1, 50, "rw");
      check_val("rw_locked_strobe", strobe_at(base).locked, 1'b1);
      push(1, 8'hD1, 1'b1);
      push(3, 8'hD3, 1'b1);
      step(1);
      check_val("rw_pre_busy",   arb_bus.r_busy,       1'b1);
      check_val("rw_pre_ready",  arb_bus.w_uart_ready, 1'b0);
      check_val("rw_pre_locked", arb_bus.r_locked,     1'b1);
      w_rst_n = 1'b0;
      #1;
      check_reset_outputs("rw_rst");
      step(1);
      w_rst_n = 1'b1;
      n = 0;
      while (arb_bus.w_uart_ready !== 1'b1 && n < 20) begin
         step(1);
         n++;
      end
      check_val("rw_ready_back", arb_bus.w_uart_ready, 1'b1);
      check_val("rw_no_early",   log_q.size(),         base + 1);
      wait_strobes(base + 3, 60, "rw_post");
      s = strobe_at(base + 1);
      check_val("rw_grant0",  s.grant,  2'd1);
      check_val("rw_data0",   s.data,   8'hD1);
      check_val("rw_locked0", s.locked, 1'b0);
      s = strobe_at(base + 2);
      check_val("rw_grant1",  s.grant,  2'd3);
      check_val("rw_data1",   s.data,   8'hD3);

      // Lock holder disappears; req3 waits
      step(10);
      reset_dut();
      base = log_q.size();
      push(0, 8'hE0, 1'b0);
      wait_strobes(base + 1, 50, "to_hold");
      s0 = strobe_at(base);
      check_val("to_hold_grant",  s0.grant,  2'd0);
      check_val("to_hold_locked", s0.locked, 1'b1);
      push(3, 8'hF3, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
      wait_strobes(base + 2, 80, "to_rel");
      s = strobe_at(base + 1);
      check_val("to_rel_grant",  s.grant,          2'd3);
      check_val("to_rel_data",   s.data,           8'hF3);
      check_val("to_rel_locked", s.locked,         1'b0);
      check_val("to_rel_gap",    s.cyc - s0.cyc,   32'd23);
`else
      step(80);
      check_val("to_never",        log_q.size(),     base + 1);
      check_val("to_still_locked", arb_bus.r_locked, 1'b1);
      check_val("to_still_grant",  arb_bus.r_grant,  2'd0);
`endif

      check_val("ack_per_byte", ack_total, log_q.size());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
